// File: rtl/tiro_jogador.sv
// Player-shot controller and bullet/enemy hit detector.
// Holds a single bullet that is launched from the player cannon on a fire
// press and climbs VEL pixels every TICK_DIV cycles. An overlap with the
// enemy box produces a one-cycle acerto pulse and adds PONTOS_ACERTO to a
// saturating score.
module tiro_jogador #(
    parameter int TICK_DIV      = 250000,
    parameter int VEL           = 8,
    parameter int BALA_L        = 4,
    parameter int BALA_A        = 10,
    parameter int PONTOS_ACERTO = 10
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        reiniciarJogo,
    input  logic        pausa,
    input  logic        disparo,
    input  logic [9:0]  jogadorX,
    input  logic [9:0]  jogadorY,
    input  logic [9:0]  jogadorLargura,
    input  logic [9:0]  inimigoX,
    input  logic [9:0]  inimigoY,
    input  logic [9:0]  inimigoLargura,
    input  logic [9:0]  inimigoAltura,
    output logic [9:0]  balaX,
    output logic [9:0]  balaY,
    output logic        balaAtiva,
    output logic        acerto,
    output logic [15:0] pontos
);

    typedef enum logic [1:0] {
        OCIOSO,
        VOANDO,
        ACERTO
    } estado_t;

    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

    estado_t       estado_q, estado_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [9:0]    bala_x_q, bala_x_d;
    logic [9:0]    bala_y_q, bala_y_d;
    logic          bala_ativa_q, bala_ativa_d;
    logic          acerto_q, acerto_d;
    logic [15:0]   pontos_q, pontos_d;
    logic          disparo_ant_q, disparo_ant_d;

    logic          limpar;
    logic          tick;
    logic          colide;
    logic          borda_disparo;
    logic          pode_disparar;
    logic [9:0]    nasce_x;
    logic [9:0]    nasce_y;
    logic [16:0]   pontos_soma;
    logic [15:0]   pontos_sat;

    // Either reset source returns the block to its power-up state.
    assign limpar = reset | reiniciarJogo;

    // Step timer: free-running divider that freezes while paused.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        tick       = 1'b0;
        tick_cnt_d = tick_cnt_q;
        if (!pausa) begin
            if (tick_cnt_q == TICK_MAX) begin
                tick       = 1'b1;
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    // Box overlap between the bullet and the enemy; sums are widened so nothing wraps.
    always_comb begin
        logic [10:0] ini_dir, ini_base, bala_dir, bala_base;
        ini_dir   = {1'b0, inimigoX} + {1'b0, inimigoLargura};
        ini_base  = {1'b0, inimigoY} + {1'b0, inimigoAltura};
        bala_dir  = {1'b0, bala_x_q} + 11'(BALA_L);
        bala_base = {1'b0, bala_y_q} + 11'(BALA_A);
        colide    = ({1'b0, bala_x_q} < ini_dir)  && (bala_dir  > {1'b0, inimigoX}) &&
                    ({1'b0, bala_y_q} < ini_base) && (bala_base > {1'b0, inimigoY});
    end

    // Launch geometry, fire-edge detection and saturating score increment.
    always_comb begin
        borda_disparo = disparo & ~disparo_ant_q;
        pode_disparar = (jogadorY >= 10'(BALA_A));
        nasce_x       = jogadorX + ((jogadorLargura - 10'(BALA_L)) >> 1);
        nasce_y       = jogadorY - 10'(BALA_A);
        pontos_soma   = {1'b0, pontos_q} + 17'(PONTOS_ACERTO);
        pontos_sat    = pontos_soma[16] ? 16'hFFFF : pontos_soma[15:0];
    end

    // Bullet FSM: next state and next register values.
    always_comb begin
        estado_d      = estado_q;
        bala_x_d      = bala_x_q;
        bala_y_d      = bala_y_q;
        bala_ativa_d  = bala_ativa_q;
        acerto_d      = 1'b0;
        pontos_d      = pontos_q;
        disparo_ant_d = disparo;

        unique case (estado_q)
            OCIOSO: begin
                if (borda_disparo && !pausa && pode_disparar) begin
                    bala_x_d     = nasce_x;
                    bala_y_d     = nasce_y;
                    bala_ativa_d = 1'b1;
                    estado_d     = VOANDO;
                end
            end
            VOANDO: begin
                if (!pausa) begin
                    if (colide) begin
                        // Collision outranks a step landing in the same cycle.
                        acerto_d     = 1'b1;
                        bala_ativa_d = 1'b0;
                        pontos_d     = pontos_sat;
                        estado_d     = ACERTO;
                    end else if (tick && (bala_y_q < 10'(VEL))) begin
                        bala_ativa_d = 1'b0;
                        estado_d     = OCIOSO;
                    end else if (tick) begin
                        bala_y_d = bala_y_q - 10'(VEL);
                    end
                end
            end
            ACERTO: begin
                // acerto is presented for this one cycle; fire presses are dropped here.
                estado_d = OCIOSO;
            end
            default: begin
                estado_d     = OCIOSO;
                bala_ativa_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous clear; a held button must not fire after reset.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (limpar) begin
            estado_q      <= OCIOSO;
            tick_cnt_q    <= '0;
            bala_x_q      <= '0;
            bala_y_q      <= '0;
            bala_ativa_q  <= 1'b0;
            acerto_q      <= 1'b0;
            pontos_q      <= '0;
            disparo_ant_q <= 1'b1;
        end else begin
            estado_q      <= estado_d;
            tick_cnt_q    <= tick_cnt_d;
            bala_x_q      <= bala_x_d;
            bala_y_q      <= bala_y_d;
            bala_ativa_q  <= bala_ativa_d;
            acerto_q      <= acerto_d;
            pontos_q      <= pontos_d;
            disparo_ant_q <= disparo_ant_d;
        end
    end

    assign balaX     = bala_x_q;
    assign balaY     = bala_y_q;
    assign balaAtiva = bala_ativa_q;
    assign acerto    = acerto_q;
    assign pontos    = pontos_q;

endmodule

// File: tb/tb_tiro_jogador.sv
// Directed bench for tiro_jogador with a 4-cycle step divider.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_tiro_jogador;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reiniciarJogo = 1'b0;
    logic        pausa = 1'b0;
    logic        disparo = 1'b0;
    logic [9:0]  jogadorX = '0, jogadorY = '0, jogadorLargura = '0;
    logic [9:0]  inimigoX = '0, inimigoY = '0, inimigoLargura = '0, inimigoAltura = '0;
    logic [9:0]  balaX, balaY;
    logic        balaAtiva, acerto;
    logic [15:0] pontos;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    tiro_jogador #(
        .TICK_DIV(4), .VEL(8), .BALA_L(4), .BALA_A(10), .PONTOS_ACERTO(10)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .reiniciarJogo(reiniciarJogo), .pausa(pausa),
        .disparo(disparo), .jogadorX(jogadorX), .jogadorY(jogadorY),
        .jogadorLargura(jogadorLargura), .inimigoX(inimigoX), .inimigoY(inimigoY),
        .inimigoLargura(inimigoLargura), .inimigoAltura(inimigoAltura),
        .balaX(balaX), .balaY(balaY), .balaAtiva(balaAtiva), .acerto(acerto), .pontos(pontos)
    );

    // Advance n rising edges and settle.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_jogador(input logic [9:0] x, input logic [9:0] y, input logic [9:0] l);
        jogadorX = x; jogadorY = y; jogadorLargura = l;
    endtask

    task automatic set_inimigo(input logic [9:0] x, input logic [9:0] y,
                               input logic [9:0] l, input logic [9:0] a);
        inimigoX = x; inimigoY = y; inimigoLargura = l; inimigoAltura = a;
    endtask

    // Two reset edges; afterwards the divider is 0 and the next edge is "edge 1".
    task automatic do_reset();
        reset = 1'b1; pausa = 1'b0; reiniciarJogo = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    // Reset, release the button for edge 1, fire on edge 2 (divider goes 1 -> 2).
    task automatic reset_and_fire();
        disparo = 1'b0;
        do_reset();
        step(1);
        disparo = 1'b1;
        step(1);
        disparo = 1'b0;
    endtask

    task automatic test_reset();
        disparo = 1'b0;
        do_reset();
        checks++;
        if ({balaAtiva, acerto, pontos, balaX, balaY} !== 38'd0) begin
            errors++;
            $display("FAIL reset_state: got act=%b hit=%b pts=%0d x=%0d y=%0d expected all zero",
                     balaAtiva, acerto, pontos, balaX, balaY);
        end
    endtask

    task automatic test_fire_open();
        logic [9:0] exp_y;
        set_inimigo(0, 0, 10, 10);
        set_jogador(300, 440, 40);
        reset_and_fire();
        checks++;
        if ({balaAtiva, balaX, balaY} !== {1'b1, 10'd318, 10'd430}) begin
            errors++;
            $display("FAIL fire_launch: got act=%b x=%0d y=%0d expected act=1 x=318 y=430",
                     balaAtiva, balaX, balaY);
        end
        for (int i = 3; i <= 12; i++) begin
            step(1);
            exp_y = 10'(430 - 8 * (i / 4));
            checks++;
            if ({balaAtiva, balaX, balaY} !== {1'b1, 10'd318, exp_y}) begin
                errors++;
                $display("FAIL fire_climb edge %0d: got act=%b x=%0d y=%0d expected act=1 x=318 y=%0d",
                         i, balaAtiva, balaX, balaY, exp_y);
            end
        end
    endtask

    task automatic test_hit();
        set_inimigo(310, 400, 30, 30);
        set_jogador(300, 440, 40);
        reset_and_fire();
        step(1);
        checks++;
        if ({balaAtiva, acerto, balaY} !== {1'b1, 1'b0, 10'd430}) begin
            errors++;
            $display("FAIL hit_touching: got act=%b hit=%b y=%0d expected act=1 hit=0 y=430",
                     balaAtiva, acerto, balaY);
        end
        step(1);
        checks++;
        if ({balaAtiva, acerto, balaY} !== {1'b1, 1'b0, 10'd422}) begin
            errors++;
            $display("FAIL hit_overlap_cycle: got act=%b hit=%b y=%0d expected act=1 hit=0 y=422",
                     balaAtiva, acerto, balaY);
        end
        step(1);
        checks++;
        if ({balaAtiva, acerto, pontos} !== {1'b0, 1'b1, 16'd10}) begin
            errors++;
            $display("FAIL hit_pulse: got act=%b hit=%b pts=%0d expected act=0 hit=1 pts=10",
                     balaAtiva, acerto, pontos);
        end
        step(1);
        checks++;
        if ({balaAtiva, acerto, pontos} !== {1'b0, 1'b0, 16'd10}) begin
            errors++;
            $display("FAIL hit_pulse_end: got act=%b hit=%b pts=%0d expected act=0 hit=0 pts=10",
                     balaAtiva, acerto, pontos);
        end
    endtask

    task automatic test_hit_on_tick();
        set_inimigo(0, 0, 10, 10);
        set_jogador(300, 440, 40);
        reset_and_fire();
        step(1);
        // Enemy arrives on the bullet just before the edge that also carries a step.
        set_inimigo(300, 420, 40, 40);
        step(1);
        checks++;
        if ({balaAtiva, acerto, pontos, balaY} !== {1'b0, 1'b1, 16'd10, 10'd430}) begin
            errors++;
            $display("FAIL hit_on_tick: got act=%b hit=%b pts=%0d y=%0d expected act=0 hit=1 pts=10 y=430",
                     balaAtiva, acerto, pontos, balaY);
        end
    endtask

    task automatic test_miss();
        set_inimigo(0, 300, 30, 30);
        set_jogador(300, 18, 40);
        reset_and_fire();
        checks++;
        if ({balaAtiva, balaY} !== {1'b1, 10'd8}) begin
            errors++;
            $display("FAIL miss_launch: got act=%b y=%0d expected act=1 y=8", balaAtiva, balaY);
        end
        step(2);
        checks++;
        if ({balaAtiva, balaY} !== {1'b1, 10'd0}) begin
            errors++;
            $display("FAIL miss_step_to_0: got act=%b y=%0d expected act=1 y=0", balaAtiva, balaY);
        end
        step(3);
        checks++;
        if ({balaAtiva, balaY} !== {1'b1, 10'd0}) begin
            errors++;
            $display("FAIL miss_wait: got act=%b y=%0d expected act=1 y=0", balaAtiva, balaY);
        end
        step(1);
        checks++;
        if ({balaAtiva, acerto, pontos} !== {1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL miss_off_top: got act=%b hit=%b pts=%0d expected act=0 hit=0 pts=0",
                     balaAtiva, acerto, pontos);
        end
        // Too close to the top edge to launch.
        jogadorY = 10'd9;
        disparo = 1'b1; step(1); disparo = 1'b0;
        checks++;
        if (balaAtiva !== 1'b0) begin
            errors++;
            $display("FAIL fire_too_high: got act=%b expected act=0", balaAtiva);
        end
        step(1);
        jogadorY = 10'd10;
        disparo = 1'b1; step(1); disparo = 1'b0;
        checks++;
        if ({balaAtiva, balaX, balaY} !== {1'b1, 10'd318, 10'd0}) begin
            errors++;
            $display("FAIL fire_at_limit: got act=%b x=%0d y=%0d expected act=1 x=318 y=0",
                     balaAtiva, balaX, balaY);
        end
        step(4);
        checks++;
        if ({balaAtiva, acerto, pontos} !== {1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL miss_from_0: got act=%b hit=%b pts=%0d expected act=0 hit=0 pts=0",
                     balaAtiva, acerto, pontos);
        end
    endtask

    task automatic test_held_button();
        int fired;
        set_inimigo(0, 0, 10, 10);
        set_jogador(300, 440, 40);
        disparo = 1'b1;
        do_reset();
        fired = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (balaAtiva !== 1'b0) fired++;
        end
        checks++;
        if (fired != 0) begin
            errors++;
            $display("FAIL held_no_fire: got %0d active cycles expected 0", fired);
        end
        disparo = 1'b0; step(1);
        disparo = 1'b1; step(1);
        checks++;
        if ({balaAtiva, balaX} !== {1'b1, 10'd318}) begin
            errors++;
            $display("FAIL refire: got act=%b x=%0d expected act=1 x=318", balaAtiva, balaX);
        end
        disparo = 1'b0; step(1);
        set_jogador(100, 440, 40);
        disparo = 1'b1; step(1);
        disparo = 1'b0;
        checks++;
        if ({balaAtiva, balaX} !== {1'b1, 10'd318}) begin
            errors++;
            $display("FAIL second_press_ignored: got act=%b x=%0d expected act=1 x=318",
                     balaAtiva, balaX);
        end
    endtask

    task automatic test_pause();
        int bad;
        set_inimigo(0, 0, 10, 10);
        set_jogador(300, 440, 40);
        reset_and_fire();
        // Divider is 2 here and must stay there through the pause.
        pausa = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if ({balaAtiva, acerto, balaY} !== {1'b1, 1'b0, 10'd430}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pause_hold: got %0d bad cycles expected 0 (y=%0d)", bad, balaY);
        end
        pausa = 1'b0;
        step(1);
        checks++;
        if (balaY !== 10'd430) begin
            errors++;
            $display("FAIL pause_resume_count: got y=%0d expected y=430", balaY);
        end
        step(1);
        checks++;
        if (balaY !== 10'd422) begin
            errors++;
            $display("FAIL pause_resume_step: got y=%0d expected y=422", balaY);
        end
        pausa = 1'b1;
        set_inimigo(300, 400, 40, 40);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if ({balaAtiva, acerto, balaY} !== {1'b1, 1'b0, 10'd422}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pause_no_hit: got %0d bad cycles expected 0 (hit=%b)", bad, acerto);
        end
        pausa = 1'b0;
        step(1);
        checks++;
        if ({balaAtiva, acerto, pontos, balaY} !== {1'b0, 1'b1, 16'd10, 10'd422}) begin
            errors++;
            $display("FAIL pause_hit_after: got act=%b hit=%b pts=%0d y=%0d expected act=0 hit=1 pts=10 y=422",
                     balaAtiva, acerto, pontos, balaY);
        end
        step(1);
        // Reset while a bullet is in flight.
        set_inimigo(0, 0, 10, 10);
        disparo = 1'b1; step(1); disparo = 1'b0;
        checks++;
        if ({balaAtiva, pontos} !== {1'b1, 16'd10}) begin
            errors++;
            $display("FAIL midflight_launch: got act=%b pts=%0d expected act=1 pts=10", balaAtiva, pontos);
        end
        reset = 1'b1; step(1); reset = 1'b0;
        checks++;
        if ({balaAtiva, acerto, pontos} !== {1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL midflight_reset: got act=%b hit=%b pts=%0d expected act=0 hit=0 pts=0",
                     balaAtiva, acerto, pontos);
        end
    endtask

    // Enemy sits on the launch point so every shot hits one edge after it fires.
    task automatic test_back_to_back();
        set_inimigo(300, 420, 40, 40);
        set_jogador(300, 440, 40);
        disparo = 1'b0;
        do_reset();
        step(1);
        for (int i = 0; i < 6553; i++) begin
            disparo = 1'b1; step(1);
            disparo = 1'b0; step(2);
        end
        checks++;
        if ({balaAtiva, pontos} !== {1'b0, 16'd65530}) begin
            errors++;
            $display("FAIL score_65530: got act=%b pts=%0d expected act=0 pts=65530", balaAtiva, pontos);
        end
        disparo = 1'b1; step(1);
        disparo = 1'b0;
        checks++;
        if (balaAtiva !== 1'b1) begin
            errors++;
            $display("FAIL sat_launch: got act=%b expected act=1", balaAtiva);
        end
        step(1);
        checks++;
        if ({balaAtiva, acerto, pontos} !== {1'b0, 1'b1, 16'hFFFF}) begin
            errors++;
            $display("FAIL sat_hit: got act=%b hit=%b pts=%0d expected act=0 hit=1 pts=65535",
                     balaAtiva, acerto, pontos);
        end
        // Press lands while the hit cycle is being presented.
        disparo = 1'b1; step(1);
        checks++;
        if ({balaAtiva, acerto} !== {1'b0, 1'b0}) begin
            errors++;
            $display("FAIL press_in_acerto: got act=%b hit=%b expected act=0 hit=0", balaAtiva, acerto);
        end
        step(1);
        checks++;
        if (balaAtiva !== 1'b0) begin
            errors++;
            $display("FAIL press_in_acerto_held: got act=%b expected act=0", balaAtiva);
        end
        disparo = 1'b0; step(1);
        disparo = 1'b1; step(1);
        disparo = 1'b0; step(1);
        checks++;
        if ({acerto, pontos} !== {1'b1, 16'hFFFF}) begin
            errors++;
            $display("FAIL sat_hold: got hit=%b pts=%0d expected hit=1 pts=65535", acerto, pontos);
        end
        step(1);
        set_inimigo(0, 0, 10, 10);
        disparo = 1'b1; step(1); disparo = 1'b0;
        checks++;
        if ({balaAtiva, pontos} !== {1'b1, 16'hFFFF}) begin
            errors++;
            $display("FAIL restart_launch: got act=%b pts=%0d expected act=1 pts=65535", balaAtiva, pontos);
        end
        reiniciarJogo = 1'b1; step(1); reiniciarJogo = 1'b0;
        checks++;
        if ({balaAtiva, acerto, pontos} !== {1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL restart_clear: got act=%b hit=%b pts=%0d expected act=0 hit=0 pts=0",
                     balaAtiva, acerto, pontos);
        end
    endtask

    initial begin
        test_reset();
        test_fire_open();
        test_hit();
        test_hit_on_tick();
        test_miss();
        test_held_button();
        test_pause();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish within 5 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
